// File: rtl/cnn_ctrl_pkg.sv
// Shared control-pipeline definitions for the CNN convolution layers.
// Holds the per-layer control depths (matching each layer's multiplier/adder
// tree latency), the default sideband tag width and a constant clog2 helper
// used to size the in-flight counter.
package cnn_ctrl_pkg;

  localparam int DEFAULT_CTRL_DEPTH = 7;
  localparam int DEFAULT_TAG_W      = 4;

  // Control depth per convolution layer; each must be >= 2.
  localparam int LAYER1_CTRL_DEPTH = 7;
  localparam int LAYER2_CTRL_DEPTH = 7;
  localparam int LAYER3_CTRL_DEPTH = 9;
  localparam int LAYER4_CTRL_DEPTH = 5;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One register stage of the control pipeline: {valid, tag, last}.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              1 = load from the previous stage, 0 = hold
//   flush           synchronous clear (wins over en)
//   valid_d/tag_d/last_d   values from the previous stage (or pipeline input)
//   valid_q/tag_q/last_q   registered stage contents
module ctrl_pipe_stage #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             valid_d,
  input  logic [TAG_W-1:0] tag_d,
  input  logic             last_d,
  output logic             valid_q,
  output logic [TAG_W-1:0] tag_q,
  output logic             last_q
);

  // Sideband is gated by valid so a bubble always carries tag=0/last=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      last_q  <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      last_q  <= 1'b0;
    end else if (en) begin
      valid_q <= valid_d;
      tag_q   <= valid_d ? tag_d : '0;
      last_q  <= valid_d & last_d;
    end
  end

endmodule

// File: rtl/valid_ctrl_pipeline.sv
// Valid/sideband control pipeline keeping a bias-stage valid, its channel tag
// and last-of-tile flag aligned with the datapath through DEPTH stages.
// Supports stall (en), synchronous flush, an in-flight counter, a completion
// pulse and a sticky stall-violation error.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   en, flush              advance enable, synchronous clear
//   valid_in/tag_in/last_in  item entering stage 0
//   valid_pipeline         valid bits of stages 0..DEPTH-2
//   valid_out/tag_out/last_out  final stage contents
//   done                   valid_out & last_out
//   inflight, busy         number of valid stages, inflight != 0
//   err                    sticky: valid_in seen while stalled
module valid_ctrl_pipeline
  import cnn_ctrl_pkg::*;
#(
  parameter int DEPTH = DEFAULT_CTRL_DEPTH,
  parameter int TAG_W = DEFAULT_TAG_W,
  parameter int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             last_in,
  output logic [DEPTH-2:0] valid_pipeline,
  output logic             valid_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             last_out,
  output logic             done,
  output logic [CNT_W-1:0] inflight,
  output logic             busy,
  output logic             err
);

  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] stage_last;
  logic [TAG_W-1:0] stage_tag [DEPTH];

  logic [DEPTH-1:0] d_valid;
  logic [DEPTH-1:0] d_last;
  logic [TAG_W-1:0] d_tag [DEPTH];

  // Each stage is fed by the one before it; stage 0 by the pipeline input.
  assign d_valid  = {stage_valid[DEPTH-2:0], valid_in};
  assign d_last   = {stage_last[DEPTH-2:0], last_in};
  assign d_tag[0] = tag_in;

  for (genvar i = 1; i < DEPTH; i++) begin : g_tag_chain
    assign d_tag[i] = stage_tag[i-1];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    ctrl_pipe_stage #(
      .TAG_W(TAG_W)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .flush  (flush),
      .valid_d(d_valid[i]),
      .tag_d  (d_tag[i]),
      .last_d (d_last[i]),
      .valid_q(stage_valid[i]),
      .tag_q  (stage_tag[i]),
      .last_q (stage_last[i])
    );
  end

  assign valid_pipeline = stage_valid[DEPTH-2:0];
  assign valid_out      = stage_valid[DEPTH-1];
  assign tag_out        = stage_tag[DEPTH-1];
  assign last_out       = stage_last[DEPTH-1];
  assign done           = valid_out & last_out;
  assign busy           = (inflight != '0);

  // On a shift one item may enter and one may leave; the counter tracks the
  // net change so it always equals the number of valid stages.  A producer
  // asserting valid_in during a stall has its item dropped and raises err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
      err      <= 1'b0;
    end else if (flush) begin
      inflight <= '0;
      err      <= 1'b0;
    end else if (en) begin
      inflight <= inflight + CNT_W'(valid_in) - CNT_W'(valid_out);
    end else if (valid_in) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_valid_ctrl_pipeline.sv
// Self-checking bench for valid_ctrl_pipeline (DEPTH=7, TAG_W=4): a table of
// hand-computed vectors, hand-written multi-cycle sequences and randomized
// traffic, all compared against a queue-based model of in-flight items.
module tb_valid_ctrl_pipeline;

  localparam int DEPTH = 7;
  localparam int TAG_W = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             flush;
  logic             valid_in;
  logic [TAG_W-1:0] tag_in;
  logic             last_in;
  logic [DEPTH-2:0] valid_pipeline;
  logic             valid_out;
  logic [TAG_W-1:0] tag_out;
  logic             last_out;
  logic             done;
  logic [CNT_W-1:0] inflight;
  logic             busy;
  logic             err;

  valid_ctrl_pipeline #(
    .DEPTH(DEPTH),
    .TAG_W(TAG_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .flush         (flush),
    .valid_in      (valid_in),
    .tag_in        (tag_in),
    .last_in       (last_in),
    .valid_pipeline(valid_pipeline),
    .valid_out     (valid_out),
    .tag_out       (tag_out),
    .last_out      (last_out),
    .done          (done),
    .inflight      (inflight),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Model: every accepted item with the number of shifts it has seen so far.
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic             last;
    int               pos;
  } item_t;

  item_t mq[$];
  bit    merr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit               en;
    bit               flush;
    bit               vin;
    logic [TAG_W-1:0] tag;
    bit               last;
    bit               evo;
    logic [TAG_W-1:0] etag;
    int               einf;
    bit               eerr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the model, using the inputs currently driven.
  task automatic modelStep();
    if (flush) begin
      mq.delete();
      merr = 1'b0;
    end else if (en) begin
      foreach (mq[k]) mq[k].pos++;
      if (mq.size() > 0 && mq[0].pos >= DEPTH) void'(mq.pop_front());
      if (valid_in) mq.push_back('{tag: tag_in, last: last_in, pos: 0});
    end else if (valid_in) begin
      merr = 1'b1;
    end
  endtask

  task automatic checkOutput(input string ctx);
    logic [DEPTH-2:0] evp;
    logic             evo;
    logic [TAG_W-1:0] etag;
    logic             elast;
    evp   = '0;
    evo   = 1'b0;
    etag  = '0;
    elast = 1'b0;
    foreach (mq[k]) begin
      if (mq[k].pos == DEPTH - 1) begin
        evo   = 1'b1;
        etag  = mq[k].tag;
        elast = mq[k].last;
      end else begin
        evp[mq[k].pos] = 1'b1;
      end
    end
    chk({ctx, "/valid_pipeline"}, 32'(valid_pipeline), 32'(evp));
    chk({ctx, "/valid_out"}, 32'(valid_out), 32'(evo));
    chk({ctx, "/tag_out"}, 32'(tag_out), 32'(etag));
    chk({ctx, "/last_out"}, 32'(last_out), 32'(elast));
    chk({ctx, "/done"}, 32'(done), 32'(evo & elast));
    chk({ctx, "/inflight"}, 32'(inflight), 32'(mq.size()));
    chk({ctx, "/busy"}, 32'(busy), 32'(mq.size() != 0));
    chk({ctx, "/err"}, 32'(err), 32'(merr));
  endtask

  // Drive one cycle of inputs, clock it, then check 1ns after the edge.
  task automatic applyStimulus(input bit e, input bit f, input bit v,
                               input logic [TAG_W-1:0] t, input bit l,
                               input string ctx);
    en       = e;
    flush    = f;
    valid_in = v;
    tag_in   = t;
    last_in  = l;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(ctx);
  endtask

  task automatic addVec(input bit e, input bit f, input bit v, input logic [TAG_W-1:0] t,
                        input bit l, input bit evo, input logic [TAG_W-1:0] etag,
                        input int einf, input bit eerr);
    vecs.push_back('{e, f, v, t, l, evo, etag, einf, eerr});
  endtask

  initial begin
    int          got_tags[$];
    int          peak;
    int          seen;
    int          first_vo;
    logic [TAG_W-1:0] tmp_tag;

    rst      = 1'b1;
    en       = 1'b0;
    flush    = 1'b0;
    valid_in = 1'b0;
    tag_in   = '0;
    last_in  = 1'b0;
    mq.delete();
    merr = 1'b0;
    #12;
    checkOutput("reset");
    rst = 1'b0;

    // Single pulse, tag 5: out on the 7th edge, one cycle wide.
    addVec(1, 0, 1, 5, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 5; i++) addVec(1, 0, 0, 0, 0, 0, 0, 1, 0);
    addVec(1, 0, 0, 0, 0, 1, 5, 1, 0);
    addVec(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Same pulse with a 3-cycle stall: out 9 edges after capture.
    addVec(1, 0, 1, 5, 0, 0, 0, 1, 0);
    addVec(1, 0, 0, 0, 0, 0, 0, 1, 0);
    addVec(1, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) addVec(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) addVec(1, 0, 0, 0, 0, 0, 0, 1, 0);
    addVec(1, 0, 0, 0, 0, 1, 5, 1, 0);
    addVec(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Stall violation: item dropped, err sticky until flush.
    addVec(0, 0, 1, 3, 0, 0, 0, 0, 1);
    addVec(1, 0, 0, 0, 0, 0, 0, 0, 1);
    addVec(1, 1, 0, 0, 0, 0, 0, 0, 0);
    // valid_in during flush is dropped.
    addVec(1, 1, 1, 7, 1, 0, 0, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].en, vecs[i].flush, vecs[i].vin, vecs[i].tag, vecs[i].last, "table");
      chk($sformatf("vec%0d/valid_out", i), 32'(valid_out), 32'(vecs[i].evo));
      chk($sformatf("vec%0d/tag_out", i), 32'(tag_out), 32'(vecs[i].etag));
      chk($sformatf("vec%0d/inflight", i), 32'(inflight), 32'(vecs[i].einf));
      chk($sformatf("vec%0d/err", i), 32'(err), 32'(vecs[i].eerr));
    end

    // Streaming: 10 back-to-back items, last on tag 9.
    peak = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < 10) applyStimulus(1, 0, 1, TAG_W'(i), i == 9, "stream");
      else        applyStimulus(1, 0, 0, '0, 0, "stream");
      if (valid_out) begin
        got_tags.push_back(int'(tag_out));
        chk("stream/done_only_on_9", 32'(done), 32'(tag_out == 4'd9));
      end
      if (int'(inflight) > peak) peak = int'(inflight);
    end
    chk("stream/count", 32'(got_tags.size()), 32'd10);
    foreach (got_tags[i]) chk($sformatf("stream/order%0d", i), 32'(got_tags[i]), 32'(i));
    chk("stream/peak_inflight", 32'(peak), 32'(DEPTH));

    // Flush with 4 items in flight.
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, TAG_W'(i + 2), 0, "preflush");
    applyStimulus(1, 1, 0, '0, 0, "flush");
    chk("flush/inflight", 32'(inflight), 32'd0);
    chk("flush/busy", 32'(busy), 32'd0);
    chk("flush/valid_pipeline", 32'(valid_pipeline), 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 0, '0, 0, "postflush");
      if (valid_out) seen++;
    end
    chk("flush/no_valid_out", 32'(seen), 32'd0);

    // Asynchronous reset with 5 items in flight.
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, TAG_W'(i + 8), i == 4, "prerst");
    rst = 1'b1;
    #1;
    mq.delete();
    merr = 1'b0;
    checkOutput("rst_async");
    #1;
    rst = 1'b0;
    first_vo = -1;
    seen     = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 0, i == 0, 4'hA, 0, "postrst");
      if (valid_out) begin
        seen++;
        if (first_vo < 0) first_vo = i;
      end
    end
    chk("rst/single_out", 32'(seen), 32'd1);
    chk("rst/latency", 32'(first_vo), 32'(DEPTH - 1));

    // Randomized traffic with occasional stall violations and flushes.
    for (int i = 0; i < 400; i++) begin
      bit e, f, v;
      e = ($urandom_range(0, 99) < 75);
      f = ($urandom_range(0, 99) < 3);
      v = e ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 5);
      tmp_tag = TAG_W'($urandom);
      applyStimulus(e, f, v, tmp_tag, $urandom_range(0, 3) == 0, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net: the stimulus is finite, so this should never trigger.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/valid_ctrl_pipeline.md
# valid_ctrl_pipeline

Parametrised valid/sideband control pipeline for the CNN convolution layers. It delays a bias-stage valid strobe, a channel tag and a last-of-tile flag through DEPTH register stages so they stay aligned with the datapath multiplier/adder tree. Unlike the fixed per-layer control pipelines, it supports stall (en), synchronous flush, an in-flight counter, and a completion pulse. One instance per layer replaces the per-layer fixed-depth control blocks.

## Interface
Parameters:
- DEPTH, 7, number of register stages (>=2); equals valid_in -> valid_out latency in cycles with en held high.
- TAG_W, 4, width of the sideband tag carried with each valid.
- CNT_W, $clog2(DEPTH+1), width of the in-flight counter (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  advance enable; 1 = all stages shift one place, 0 = all stages hold.
- flush  in  1  synchronous clear of all stage valids, tags, last flags and counter.
- valid_in  in  1  valid strobe from the bias stage.
- tag_in  in  TAG_W  sideband tag (output-channel index) qualified by valid_in.
- last_in  in  1  last item of tile, qualified by valid_in.
- valid_pipeline  out  DEPTH-1  valid bit of stages 0..DEPTH-2 (bit i = stage i).
- valid_out  out  1  valid of final stage DEPTH-1.
- tag_out  out  TAG_W  tag of final stage.
- last_out  out  1  last flag of final stage.
- done  out  1  valid_out & last_out.
- inflight  out  CNT_W  count of stages currently holding a valid item (0..DEPTH).
- busy  out  1  inflight != 0.
- err  out  1  sticky protocol error.

## Operation
- Stage 0 captures {valid_in, tag_in, last_in}; stage i captures stage i-1; stage DEPTH-1 drives valid_out/tag_out/last_out.
- Priority per cycle: rst > flush > en > hold.
- flush=1: every stage valid, tag, last -> 0; inflight -> 0; err -> 0. en ignored that cycle; valid_in that cycle is dropped.
- en=1, flush=0: full shift; item in stage DEPTH-1 leaves (consumed by datapath).
- en=0, flush=0: all stage registers and inflight hold; valid_in not sampled.
- tag/last registers of an invalid stage are don't-care on read but must load 0 when valid_in=0 (keeps tag_out=0 on bubbles; checked by bench).
- inflight update when shifting: inflight + valid_in - valid_out (both 1 -> unchanged). Must always equal popcount of {valid_out, valid_pipeline}; saturation never needed (max DEPTH).
- err set (sticky) when valid_in=1 while en=0 and flush=0 (producer violated stall). Cleared only by rst or flush.
- No state machine beyond the shift register; inflight counter and err flag are the only non-shift state.

## Timing
- Reset values: valid_pipeline=0, valid_out=0, tag_out=0, last_out=0, done=0, inflight=0, busy=0, err=0.
- Latency: valid_in at edge N (en=1 continuously) -> valid_out high after edge N+DEPTH-1 (i.e. visible cycle N+DEPTH-1 to N+DEPTH window; DEPTH register stages). DEPTH=7 gives 7-cycle valid delay.
- Each en=0 cycle adds exactly one cycle of latency to every in-flight item; no item duplicated or lost.
- done, busy combinational from registers only (no input-to-output paths); all other outputs registered.
- Back-to-back valid_in for K cycles -> K consecutive valid_out cycles, order and tags preserved.
- rst asserted mid-stream clears everything immediately (asynchronous); first item after release needs full DEPTH cycles.

## Structure
- Shared package cnn_ctrl_pkg: default DEPTH per layer (LAYERn_CTRL_DEPTH constants), TAG_W default, clog2 helper function.
- Sub-module ctrl_pipe_stage: one register stage {valid, tag, last} with en/flush/rst; instantiated DEPTH times via generate. Counter and err logic in top.

## Test plan
- Reset/defaults: DEPTH=7, single valid_in=1 tag=5 at cycle 0, en=1 -> valid_out=1, tag_out=5 exactly 7 edges later, one cycle wide; inflight goes 1 for 7 cycles then 0.
- Stall: same pulse, en=0 for 3 cycles mid-flight -> valid_out at edge 10; inflight constant during stall; err stays 0.
- Streaming: valid_in high 10 cycles, tags 0..9, last on tag 9 -> valid_out 10 cycles, tags 0..9 in order, done only with tag 9; inflight peaks at 7.
- Flush: 4 items in flight, flush=1 for one cycle -> all valids 0, inflight=0, busy=0 next cycle; no valid_out afterward.
- Protocol error: valid_in=1 while en=0 -> err=1 next edge, held until flush; item not captured, inflight unchanged.
- Async reset mid-stream: rst pulse between edges with 5 items in flight -> all outputs 0 immediately, no stale valid_out after release.
